// File: rtl/rr_select_arbiter.sv
// Eight-requester round-robin arbiter with a registered 3-bit grant index.
// Grants persist until release, owner drop, or an optional hold timeout.
module rr_select_arbiter #(
    parameter int HOLD_W   = 8,
    parameter int MAX_HOLD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req_i,
    input  logic       release_i,
    output logic [2:0] gnt_idx_o,
    output logic       gnt_valid_o,
    output logic       timeout_o,
    output logic [2:0] ptr_o
);

    localparam bit TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        TIMEOUT_EN ? HOLD_W'(MAX_HOLD - 1) : '0;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t            state_q;
    logic [2:0]        gnt_idx_q;
    logic [2:0]        ptr_q;
    logic              gnt_valid_q;
    logic              timeout_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;

    logic [2:0]        scan_idx;
    logic [2:0]        win_idx;
    logic              req_any;
    logic              owner_drop;
    logic              hold_expired;
    logic              grant_end;
    logic              timeout_only;

    // Walk offsets from far to near so the requester closest to ptr wins last.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        scan_idx = '0;
        win_idx  = ptr_q;
        for (int k = 7; k >= 0; k--) begin
            scan_idx = ptr_q + 3'(k);
            if (req_i[scan_idx]) begin
                win_idx = scan_idx;
            end
        end
    end

    always_comb begin
        req_any      = |req_i;
        hold_cnt_d   = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
        owner_drop   = ~req_i[gnt_idx_q];
        hold_expired = TIMEOUT_EN && (hold_cnt_q == HOLD_LAST);
        grant_end    = release_i | owner_drop | hold_expired;
        timeout_only = hold_expired & ~release_i & ~owner_drop;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    timeout_q <= 1'b0;
                    if (req_any) begin
                        gnt_idx_q   <= win_idx;
                        gnt_valid_q <= 1'b1;
                        hold_cnt_q  <= '0;
                        state_q     <= S_GRANT;
                    end else begin
                        gnt_valid_q <= 1'b0;
                    end
                end
                S_GRANT: begin
                    if (grant_end) begin
                        // Returning to IDLE gives the mandatory turnaround cycle.
                        gnt_valid_q <= 1'b0;
                        ptr_q       <= gnt_idx_q + 3'd1;
                        timeout_q   <= timeout_only;
                        state_q     <= S_IDLE;
                    end else begin
                        hold_cnt_q  <= hold_cnt_d;
                        timeout_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    gnt_valid_q <= 1'b0;
                    timeout_q   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_idx_o   = gnt_idx_q;
    assign gnt_valid_o = gnt_valid_q;
    assign timeout_o   = timeout_q;
    assign ptr_o       = ptr_q;

endmodule
